// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller sharing the 8-bit RAM/IO port
// between instruction fetch and the load/store buffer. Arbitrates, splits
// accesses into byte transfers, reassembles read data, honours flush,
// IO back-pressure and the global rdy pause.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_LS = 1'b1;

   logic [1:0]  state;
   logic [2:0]  cnt;
   logic [2:0]  nbytes;
   logic [31:0] base;
   logic [31:0] wdata;
   logic [31:0] rd_buf;
   logic        is_ls;
   logic        last_grant;
   logic        mem_wr_q;
   logic        act_q;
   logic [7:0]  din_hold;

   logic        if_elig, ls_elig, pick_ls, grant, g_we, g_stall, io_stall;
   logic [2:0]  ls_n, g_n;
   logic [31:0] g_addr, rd_next;
   logic [7:0]  din, wr_byte;
   logic [1:0]  lane;

   // Arbitration, byte selection and read-data assembly.
   always_comb begin
      if_elig = if_req & ~if_done;
      ls_elig = ls_req & ~ls_done;
      pick_ls = ls_elig & (~if_elig | (last_grant == GNT_IF));
      grant   = (if_elig | ls_elig) & ~clear;
      case (ls_size)
         2'd0:    ls_n = 3'd1;
         2'd1:    ls_n = 3'd2;
         default: ls_n = 3'd4;
      endcase
      g_n     = pick_ls ? ls_n : 3'd4;
      g_addr  = pick_ls ? ls_addr : if_addr;
      g_we    = pick_ls & ls_we;
      g_stall = (ls_addr[17:16] == 2'b11) & io_buffer_full;
      io_stall = (base[17:16] == 2'b11) & io_buffer_full;
      // After a pause the RAM has moved on; use the byte saved on the first paused edge.
      din     = act_q ? mem_din : din_hold;
      lane    = cnt[1:0] - 2'd2;
      rd_next = rd_buf;
      rd_next[{lane, 3'b000} +: 8] = din;
      wr_byte = wdata[{cnt[1:0], 3'b000} +: 8];
   end

   assign mem_wr = mem_wr_q & rdy;

   // Remember the RAM byte that was due when a pause began.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_q    <= 1'b1;
         din_hold <= 8'h00;
      end else begin
         act_q <= rdy;
         if (act_q) din_hold <= mem_din;
      end
   end

   // Main controller: grant, byte issue/capture, completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         nbytes     <= 3'd0;
         base       <= 32'h0;
         wdata      <= 32'h0;
         rd_buf     <= 32'h0;
         is_ls      <= 1'b0;
         last_grant <= GNT_IF;
         mem_wr_q   <= 1'b0;
         mem_a      <= 32'h0;
         mem_dout   <= 8'h00;
         if_done    <= 1'b0;
         if_data    <= 32'h0;
         ls_done    <= 1'b0;
         ls_rdata   <= 32'h0;
      end else begin
         // Done strobes last exactly one cycle, even across a pause.
         if_done <= 1'b0;
         ls_done <= 1'b0;
         if (rdy) begin
            case (state)
               S_IDLE: begin
                  if (grant) begin
                     last_grant <= pick_ls;
                     is_ls      <= pick_ls;
                     base       <= g_addr;
                     nbytes     <= g_n;
                     wdata      <= ls_wdata;
                     rd_buf     <= 32'h0;
                     mem_a      <= g_addr;
                     if (g_we) begin
                        state <= S_WRITE;
                        if (g_stall) begin
                           cnt      <= 3'd0;
                           mem_wr_q <= 1'b0;
                        end else begin
                           cnt      <= 3'd1;
                           mem_wr_q <= 1'b1;
                           mem_dout <= ls_wdata[7:0];
                        end
                     end else begin
                        state <= S_READ;
                        cnt   <= 3'd1;
                     end
                  end
               end
               S_READ: begin
                  if (clear) begin
                     state <= S_IDLE;
                     cnt   <= 3'd0;
                     mem_a <= 32'h0;
                  end else begin
                     if (cnt >= 3'd2) rd_buf <= rd_next;
                     if (cnt < nbytes) mem_a <= base + {29'b0, cnt};
                     if (cnt == nbytes + 3'd1) begin
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                        if (is_ls) begin
                           ls_done  <= 1'b1;
                           ls_rdata <= rd_next;
                        end else begin
                           if_done <= 1'b1;
                           if_data <= rd_next;
                        end
                     end else begin
                        cnt <= cnt + 3'd1;
                     end
                  end
               end
               S_WRITE: begin
                  // Stores are committed, so clear has no effect here.
                  if (cnt == nbytes) begin
                     mem_wr_q <= 1'b0;
                     ls_done  <= 1'b1;
                     state    <= S_IDLE;
                     cnt      <= 3'd0;
                  end else if (io_stall) begin
                     mem_wr_q <= 1'b0;
                  end else begin
                     mem_a    <= base + {29'b0, cnt};
                     mem_dout <= wr_byte;
                     mem_wr_q <= 1'b1;
                     cnt      <= cnt + 3'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: synchronous byte RAM model on the bus, scenario
// tasks with directed and randomized accesses checked against a
// transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_ctrl;

   logic        clk, rst, rdy, clear;
   logic        if_req, if_done;
   logic [31:0] if_addr, if_data;
   logic        ls_req, ls_we, ls_done;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;

   int cmp = 0;
   int err = 0;

   logic [7:0]  ram [0:65535];
   logic [7:0]  mdl [0:65535];
   logic [39:0] wlog [$];

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running synchronous RAM: one-cycle read latency, logs every write.
   always @(posedge clk) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) begin
         ram[mem_a[15:0]] = mem_dout;
         wlog.push_back({mem_a, mem_dout});
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int nb(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
      logic [31:0] r, ak;
      r = 32'h0;
      for (int k = 0; k < n; k++) begin
         ak = a + 32'(k);
         r[8*k +: 8] = mdl[ak[15:0]];
      end
      return r;
   endfunction

   task automatic poke(input logic [31:0] a, input logic [7:0] v);
      ram[a[15:0]] = v;
      mdl[a[15:0]] = v;
   endtask

   task automatic apply_reset();
      rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Raise one request, hold it until its done strobe, report data and edge count.
   task automatic run_req(input bit is_if, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] data, output int cyc);
      cyc = 0;
      data = 32'h0;
      if (is_if) begin
         if_addr = addr; if_req = 1'b1;
      end else begin
         ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wd; ls_req = 1'b1;
      end
      while (cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (is_if && if_done) begin data = if_data; break; end
         if (!is_if && ls_done) begin data = ls_rdata; break; end
      end
      if (is_if) if_req = 1'b0; else ls_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      cmp++; if (mem_a !== 32'h0)    begin err++; $display("FAIL rst_mem_a: got %h want 0", mem_a); end
      cmp++; if (mem_dout !== 8'h0)  begin err++; $display("FAIL rst_mem_dout: got %h want 0", mem_dout); end
      cmp++; if (mem_wr !== 1'b0)    begin err++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
      cmp++; if (if_done !== 1'b0)   begin err++; $display("FAIL rst_if_done: got %b want 0", if_done); end
      cmp++; if (if_data !== 32'h0)  begin err++; $display("FAIL rst_if_data: got %h want 0", if_data); end
      cmp++; if (ls_done !== 1'b0)   begin err++; $display("FAIL rst_ls_done: got %b want 0", ls_done); end
      cmp++; if (ls_rdata !== 32'h0) begin err++; $display("FAIL rst_ls_rdata: got %h want 0", ls_rdata); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fetch();
      logic [31:0] d; int cyc;
      poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
      fork
         run_req(1, 0, 2'd0, 32'h100, 32'h0, d, cyc);
         begin
            for (int k = 0; k < 4; k++) begin
               @(posedge clk); #2;
               cmp++;
               if (mem_a !== 32'h100 + 32'(k)) begin
                  err++; $display("FAIL fetch_addr%0d: got %h want %h", k, mem_a, 32'h100 + 32'(k));
               end
            end
         end
      join
      cmp++; if (cyc !== 6) begin err++; $display("FAIL fetch_latency: got %0d want 6", cyc); end
      cmp++; if (d !== 32'h00000513) begin err++; $display("FAIL fetch_data: got %h want 00000513", d); end
      @(posedge clk); #1;
   endtask

   task automatic test_byte_store();
      logic [31:0] d; int cyc;
      wlog.delete();
      fork
         run_req(0, 1, 2'd0, 32'h2000, 32'h000000AB, d, cyc);
         begin
            @(posedge clk); #2;
            cmp++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h2000 || mem_dout !== 8'hAB) begin
               err++; $display("FAIL bstore_bus: got wr=%b a=%h d=%h want wr=1 a=2000 d=ab", mem_wr, mem_a, mem_dout);
            end
            @(posedge clk); #2;
            cmp++; if (mem_wr !== 1'b0) begin err++; $display("FAIL bstore_wr_off: got %b want 0", mem_wr); end
         end
      join
      mdl[16'h2000] = 8'hAB;
      cmp++; if (cyc !== 2) begin err++; $display("FAIL bstore_latency: got %0d want 2", cyc); end
      cmp++; if (wlog.size() !== 1) begin err++; $display("FAIL bstore_count: got %0d want 1", wlog.size()); end
      else begin
         cmp++; if (wlog[0] !== {32'h2000, 8'hAB}) begin err++; $display("FAIL bstore_log: got %h want 00002000ab", wlog[0]); end
      end
      // A full IO buffer must not slow down a non-IO store.
      @(posedge clk); #1;
      wlog.delete();
      io_buffer_full = 1'b1;
      run_req(0, 1, 2'd1, 32'h2002, 32'h1234BEEF, d, cyc);
      io_buffer_full = 1'b0;
      mdl[16'h2002] = 8'hEF; mdl[16'h2003] = 8'hBE;
      cmp++; if (cyc !== 3) begin err++; $display("FAIL hstore_latency: got %0d want 3", cyc); end
      cmp++;
      if (wlog.size() !== 2 || wlog[0] !== {32'h2002, 8'hEF} || wlog[1] !== {32'h2003, 8'hBE}) begin
         err++; $display("FAIL hstore_log: got %0d entries want 2 (2002:ef, 2003:be)", wlog.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_tie();
      logic [31:0] di, dl; int ci, cl;
      apply_reset();
      poke(32'h10, 8'h34); poke(32'h11, 8'h12);
      for (int r = 0; r < 2; r++) begin
         fork
            run_req(1, 0, 2'd0, 32'h200 + 32'(r*8), 32'h0, di, ci);
            run_req(0, 0, 2'd1, 32'h10, 32'h0, dl, cl);
         join
         cmp++; if (cl !== 4) begin err++; $display("FAIL tie%0d_ls_latency: got %0d want 4", r, cl); end
         cmp++; if (dl !== 32'h00001234) begin err++; $display("FAIL tie%0d_ls_data: got %h want 00001234", r, dl); end
         cmp++; if (ci !== 10) begin err++; $display("FAIL tie%0d_if_latency: got %0d want 10", r, ci); end
         cmp++;
         if (di !== exp_read(32'h200 + 32'(r*8), 4)) begin
            err++; $display("FAIL tie%0d_if_data: got %h want %h", r, di, exp_read(32'h200 + 32'(r*8), 4));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      logic [31:0] d, prev; int cyc, seen;
      // Flush at the third edge of a fetch, then an immediate new fetch.
      if_addr = 32'h300; if_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear = 1'b1; if_req = 1'b0;
      @(posedge clk); #1;
      clear = 1'b0;
      cmp++; if (mem_a !== 32'h0) begin err++; $display("FAIL flush_mem_a: got %h want 0", mem_a); end
      run_req(1, 0, 2'd0, 32'h304, 32'h0, d, cyc);
      cmp++; if (cyc !== 6) begin err++; $display("FAIL flush_next_latency: got %0d want 6", cyc); end
      cmp++; if (d !== exp_read(32'h304, 4)) begin err++; $display("FAIL flush_next_data: got %h want %h", d, exp_read(32'h304, 4)); end
      prev = exp_read(32'h304, 4);
      @(posedge clk); #1;
      // Flush on the final edge of a fetch wins over completion.
      if_addr = 32'h308; if_req = 1'b1;
      repeat (5) @(posedge clk);
      #1 clear = 1'b1; if_req = 1'b0;
      seen = 0;
      @(posedge clk); #1;
      clear = 1'b0;
      if (if_done) seen++;
      repeat (4) begin @(posedge clk); #1; if (if_done) seen++; end
      cmp++; if (seen !== 0) begin err++; $display("FAIL flush_final_done: got %0d strobes want 0", seen); end
      cmp++; if (if_data !== prev) begin err++; $display("FAIL flush_data_hold: got %h want %h", if_data, prev); end
      // Stores ignore clear.
      wlog.delete();
      fork
         run_req(0, 1, 2'd2, 32'h400, 32'hDEADBEEF, d, cyc);
         begin @(posedge clk); #2 clear = 1'b1; @(posedge clk); #2 clear = 1'b0; end
      join
      for (int k = 0; k < 4; k++) mdl[16'h400 + 16'(k)] = 8'(32'hDEADBEEF >> (8*k));
      cmp++; if (cyc !== 5) begin err++; $display("FAIL flush_store_latency: got %0d want 5", cyc); end
      cmp++;
      if (wlog.size() !== 4 || wlog[3] !== {32'h403, 8'hDE} || wlog[0] !== {32'h400, 8'hEF}) begin
         err++; $display("FAIL flush_store_log: got %0d entries want 4", wlog.size());
      end
      @(posedge clk); #1;
      // Clear while idle holds off the grant by one edge.
      clear = 1'b1;
      fork
         run_req(1, 0, 2'd0, 32'h30C, 32'h0, d, cyc);
         begin @(posedge clk); #2 clear = 1'b0; end
      join
      cmp++; if (cyc !== 7) begin err++; $display("FAIL flush_idle_latency: got %0d want 7", cyc); end
      cmp++; if (d !== exp_read(32'h30C, 4)) begin err++; $display("FAIL flush_idle_data: got %h want %h", d, exp_read(32'h30C, 4)); end
      @(posedge clk); #1;
   endtask

   task automatic test_io_stall();
      logic [31:0] d; int cyc, bad;
      wlog.delete();
      io_buffer_full = 1'b1;
      bad = 0;
      fork
         run_req(0, 1, 2'd0, 32'h30000, 32'h00000041, d, cyc);
         begin
            for (int i = 0; i < 3; i++) begin
               @(posedge clk); #2;
               if (mem_wr !== 1'b0) bad++;
            end
            io_buffer_full = 1'b0;
            @(posedge clk); #2;
            cmp++;
            if (mem_wr !== 1'b1 || mem_dout !== 8'h41 || mem_a !== 32'h30000) begin
               err++; $display("FAIL io_issue: got wr=%b a=%h d=%h want wr=1 a=30000 d=41", mem_wr, mem_a, mem_dout);
            end
         end
      join
      mdl[16'h0000] = 8'h41;
      cmp++; if (bad !== 0) begin err++; $display("FAIL io_stall_wr: got %0d stall cycles with wr want 0", bad); end
      cmp++; if (cyc !== 5) begin err++; $display("FAIL io_latency: got %0d want 5", cyc); end
      cmp++;
      if (wlog.size() !== 1 || wlog[0] !== {32'h30000, 8'h41}) begin
         err++; $display("FAIL io_log: got %0d entries want 1 (30000:41)", wlog.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_pause();
      logic [31:0] d, hold; int cyc, moved, wr_hi;
      moved = 0;
      fork
         run_req(1, 0, 2'd0, 32'h500, 32'h0, d, cyc);
         begin
            @(posedge clk); @(posedge clk); #2;
            rdy = 1'b0; hold = mem_a;
            repeat (4) begin
               @(posedge clk); #2;
               if (mem_a !== hold || mem_wr !== 1'b0) moved++;
            end
            rdy = 1'b1;
         end
      join
      cmp++; if (moved !== 0) begin err++; $display("FAIL pause_hold: got %0d changed cycles want 0", moved); end
      cmp++; if (cyc !== 10) begin err++; $display("FAIL pause_fetch_latency: got %0d want 10", cyc); end
      cmp++; if (d !== exp_read(32'h500, 4)) begin err++; $display("FAIL pause_fetch_data: got %h want %h", d, exp_read(32'h500, 4)); end
      @(posedge clk); #1;
      wlog.delete();
      wr_hi = 0;
      fork
         run_req(0, 1, 2'd2, 32'h600, 32'hCAFEF00D, d, cyc);
         begin
            @(posedge clk); @(posedge clk); #2;
            rdy = 1'b0;
            repeat (4) begin @(posedge clk); #2; if (mem_wr !== 1'b0) wr_hi++; end
            rdy = 1'b1;
         end
      join
      for (int k = 0; k < 4; k++) mdl[16'h600 + 16'(k)] = 8'(32'hCAFEF00D >> (8*k));
      cmp++; if (wr_hi !== 0) begin err++; $display("FAIL pause_store_wr: got %0d cycles with wr want 0", wr_hi); end
      cmp++; if (cyc !== 9) begin err++; $display("FAIL pause_store_latency: got %0d want 9", cyc); end
      cmp++;
      if (wlog.size() !== 4 || wlog[1] !== {32'h601, 8'hF0} || wlog[2] !== {32'h602, 8'hFE}) begin
         err++; $display("FAIL pause_store_log: got %0d entries want 4", wlog.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [31:0] a, wd, d, e, ak, last_if, last_ls;
      logic [1:0] sz;
      int kind, n, cyc, lat, port, prev;
      bit have_if, have_ls;
      have_if = 0; have_ls = 0; prev = -1; last_if = 32'h0; last_ls = 32'h0;
      for (int i = 0; i < 60; i++) begin
         kind = (i == 0) ? 0 : (i == 1) ? 1 : int'($urandom_range(0, 2));
         sz = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + $urandom_range(0, 3);
         wd = $urandom;
         n = (kind == 0) ? 4 : nb(sz);
         port = (kind == 0) ? 0 : 1;
         lat = (kind == 2) ? n + 1 : n + 2;
         if (prev == port) lat++;
         wlog.delete();
         if (kind == 0) run_req(1, 0, 2'd0, a, 32'h0, d, cyc);
         else run_req(0, kind == 2, sz, a, wd, d, cyc);
         cmp++; if (cyc !== lat) begin err++; $display("FAIL rnd%0d_latency: kind %0d got %0d want %0d", i, kind, cyc, lat); end
         if (kind == 2) begin
            cmp++;
            if (wlog.size() !== n) begin
               err++; $display("FAIL rnd%0d_wcount: got %0d want %0d", i, wlog.size(), n);
            end else begin
               for (int k = 0; k < n; k++) begin
                  ak = a + 32'(k);
                  cmp++;
                  if (wlog[k] !== {ak, wd[8*k +: 8]}) begin
                     err++; $display("FAIL rnd%0d_wbyte%0d: got %h want %h", i, k, wlog[k], {ak, wd[8*k +: 8]});
                  end
               end
            end
            for (int k = 0; k < n; k++) begin
               ak = a + 32'(k);
               mdl[ak[15:0]] = wd[8*k +: 8];
            end
         end else begin
            e = exp_read(a, n);
            cmp++; if (d !== e) begin err++; $display("FAIL rnd%0d_data: kind %0d a=%h got %h want %h", i, kind, a, d, e); end
            if (kind == 0) begin last_if = e; have_if = 1; end
            else begin last_ls = e; have_ls = 1; end
         end
         if (port == 1 && have_if) begin
            cmp++; if (if_data !== last_if) begin err++; $display("FAIL rnd%0d_if_hold: got %h want %h", i, if_data, last_if); end
         end
         if (port == 0 && have_ls) begin
            cmp++; if (ls_rdata !== last_ls) begin err++; $display("FAIL rnd%0d_ls_hold: got %h want %h", i, ls_rdata, last_ls); end
         end
         prev = port;
         if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; prev = -1; end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h700; ls_wdata = 32'h11223344; ls_req = 1'b1;
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b1;
      #1;
      cmp++; if (mem_wr !== 1'b0)    begin err++; $display("FAIL rstmid_mem_wr: got %b want 0", mem_wr); end
      cmp++; if (mem_a !== 32'h0)    begin err++; $display("FAIL rstmid_mem_a: got %h want 0", mem_a); end
      cmp++; if (if_data !== 32'h0)  begin err++; $display("FAIL rstmid_if_data: got %h want 0", if_data); end
      cmp++; if (ls_rdata !== 32'h0) begin err++; $display("FAIL rstmid_ls_rdata: got %h want 0", ls_rdata); end
      ls_req = 1'b0;
      mdl[16'h700] = 8'h44;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i] = 8'($urandom);
         mdl[i] = ram[i];
      end
      test_reset();
      test_fetch();
      test_byte_store();
      test_tie();
      test_flush();
      test_io_stall();
      test_pause();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that shares the single 8-bit RAM/IO port between the instruction fetch path and the load/store buffer. It arbitrates between the two requesters, splits each access into byte transfers, and reassembles read data. It handles flush aborts, IO back-pressure and the global `rdy` pause. It sits between the icache/fetch unit and the LSB on one side and the top-level memory bus on the other.

## Interface
- No parameters. Address width is fixed at 32; the data bus is fixed at 8.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rdy`  in  1  global enable; low freezes the block.
- `clear`  in  1  ROB flush pulse.
- `if_req`  in  1  instruction read request, held until `if_done`.
- `if_addr`  in  32  instruction word address.
- `if_done`  out  1  one-cycle pulse, `if_data` valid.
- `if_data`  out  32  fetched word, little-endian.
- `ls_req`  in  1  LSB request, held until `ls_done`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- `ls_addr`  in  32  access address.
- `ls_wdata`  in  32  store data; the low N bytes are used.
- `ls_done`  out  1  one-cycle pulse; load data valid, or store complete.
- `ls_rdata`  out  32  load data, zero-extended (LSB performs sign extension).
- `mem_din`  in  8  RAM read data.
- `mem_dout`  out  8  RAM write data.
- `mem_a`  out  32  RAM address.
- `mem_wr`  out  1  write enable.
- `io_buffer_full`  in  1  UART buffer full.

## Operation
- **States:** IDLE, READ, WRITE. Byte counter `cnt` is 3 bits. N = bytes in the access (1, 2 or 4; 4 for fetch).
- **Arbitration (IDLE only).**
  - Eligible = `req` high and the requester's `done` is not asserted this cycle.
  - If both are eligible, grant the requester not granted last. `last_grant` resets to IF, so the first tie goes to LSB.
  - Grant to a fetch or a load goes to READ; grant to a store goes to WRITE.
  - Base address, N and write data are latched at grant.
- **READ.**
  - After grant edge E0+k (k = 0..N-1), `mem_a` = base+k.
  - `mem_din` is captured at edge E0+k+2 into byte lane k.
  - After edge E0+N+1: `done` pulses with the assembled data; state goes to IDLE.
  - Unused upper bytes are 0.
- **WRITE.**
  - After edge E0+k, `mem_a` = base+k, `mem_dout` = byte k, `mem_wr` = 1.
  - After edge E0+N: `mem_wr` = 0, `ls_done` pulses, state goes to IDLE.
- **IO stall.** If `base[17:16]` == 2'b11 and `io_buffer_full` = 1 at the edge that would issue a write byte, that byte is not issued. `mem_wr` = 0 and `cnt` holds. Issue is retried each cycle.
- **`clear`.**
  - An in-flight READ (fetch or load) aborts: at the next edge the state goes to IDLE, `mem_a` = 0, no `done` is produced, and in-pipe bytes are discarded.
  - WRITE is never aborted, because stores are committed.
  - `clear` in IDLE blocks grants for that edge.
- **`rdy` low.** All state, counters and registered outputs hold. `mem_wr` is forced to 0 combinationally. Progress resumes at the first edge with `rdy` high, with no skipped byte.
- **Address arithmetic** is 32-bit and wraps modulo 2^32.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `mem_a` 0, `mem_dout` 0, `mem_wr` 0, `if_done` 0, `if_data` 0, `ls_done` 0, `ls_rdata` 0, `last_grant` IF.
- **Read latency:** N+2 edges from grant to the `done` cycle. A word fetch is `done` after edge E0+5.
- **Write latency:** N+1 edges plus IO stall cycles.
- **Back-to-back accesses:** the earliest next grant is the edge after the `done` cycle, so one IDLE cycle separates accesses.
- **Output timing:** `done` is high for exactly one cycle. Data outputs hold their value until the next `done` of the same port.
- **Simultaneous events:**
  - `clear` and the READ final edge coincide: `clear` wins, and `done` is not asserted.
  - `rst` mid-access returns to reset values immediately.

## Test plan
- **Word fetch:** `if_req`, `if_addr`=0x100, RAM[0x100..0x103] = 13,05,00,00 -> `mem_a` 0x100..0x103 on consecutive cycles; `if_done` after edge E0+5 with `if_data`=0x00000513.
- **Byte store:** `ls_we`=1, `ls_size`=0, `ls_addr`=0x2000, `ls_wdata`=0xAB -> one cycle with `mem_wr`=1, `mem_a`=0x2000, `mem_dout`=0xAB; `ls_done` 2 edges after grant.
- **Tie arbitration:** `if_req` and an LSB half load at 0x10 (RAM 34,12) raised together after reset -> LSB first, `ls_rdata`=0x00001234. Fetch is granted on the edge after `ls_done`. Next tie goes to LSB again.
- **Flush during fetch:** `clear` pulse at E0+2 of a fetch -> no `if_done`, IDLE at the next edge, `mem_a`=0. A later fetch completes normally.
- **IO stall:** store byte 0x41 to 0x30000 with `io_buffer_full`=1 for 3 cycles -> `mem_wr` stays 0 for 3 cycles, then one write of 0x41; `ls_done` follows.
- **Pause:** `rdy` low for 4 cycles in the middle of a word fetch -> `mem_wr` 0 and outputs held; after resume, the data equals the no-pause result and latency grows by 4.
